config_add_apx_arbiter: RTL and testbench

- Shares one configurable truncation integer adder among NUM_REQ requesters using round-robin arbitration.
- Each requester owns a programmable accuracy-mode bit that drives the adder's approximate-control input on every issue from that requester.
- Tracks in-flight operations with a tag pipeline matched to the adder latency, returns each result to its issuer, and counts approximate operations per requester for accuracy/energy profiling.

---
 rtl/config_add_pkg.sv | 24 ++
 rtl/config_add_apx_arbiter_rr_arbiter.sv | 34 +++
 rtl/config_add_apx_arbiter.sv | 116 +++++++++++
 tb/tb_config_add_apx_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/config_add_pkg.sv
// Shared constants and helpers for the approximate-adder arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a.
package config_add_pkg;

    localparam int DATA_PATH_BITWIDTH = 32;

    // Accuracy-mode encodings driven onto the adder's approximate-control input.
    localparam logic MODE_EXACT = 1'b0;
    localparam logic MODE_APX   = 1'b1;

    // Ceiling log2, minimum 1 so that a 2-requester index is still one bit wide.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/config_add_apx_arbiter_rr_arbiter.sv
// Round-robin grant selection: first set request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; grant is a pure function of req and ptr.
// Ports: i req (NUM_REQ), i ptr (ID_W); o grant (one-hot), o winner (index), o any.
module rr_arbiter
    import config_add_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    always_comb begin
        int idx;
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                winner     = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/config_add_apx_arbiter.sv
// Shares one truncation adder among NUM_REQ requesters (round-robin), tags results back to issuers.
// Latency: ADD_LATENCY cycles issue-to-response; req_ready is combinational from req_valid/rr pointer.
// Backpressure: at most one issue per cycle via req_ready; responses cannot be stalled.
// Ports: clk/rst (sync, active low); req_valid/req_a/req_b/req_ready requester side;
//        cfg_we/cfg_id/cfg_apx mode writes; add_a/add_b/add_apx_ctl/add_c adder side;
//        resp_valid/resp_id/resp_data result return; apx_cnt packed per-requester approx-op counters.
module config_add_apx_arbiter #(
    parameter int DATA_PATH_BITWIDTH = config_add_pkg::DATA_PATH_BITWIDTH,
    parameter int NUM_REQ            = 4,
    parameter int ID_W               = config_add_pkg::clog2(NUM_REQ),
    parameter int ADD_LATENCY        = 2,
    parameter int CNT_W              = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*DATA_PATH_BITWIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_PATH_BITWIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic                               cfg_we,
    input  logic [ID_W-1:0]                    cfg_id,
    input  logic                               cfg_apx,
    output logic [DATA_PATH_BITWIDTH-1:0]      add_a,
    output logic [DATA_PATH_BITWIDTH-1:0]      add_b,
    output logic                               add_apx_ctl,
    input  logic [DATA_PATH_BITWIDTH-1:0]      add_c,
    output logic                               resp_valid,
    output logic [ID_W-1:0]                    resp_id,
    output logic [DATA_PATH_BITWIDTH-1:0]      resp_data,
    output logic [NUM_REQ*CNT_W-1:0]           apx_cnt
);
    import config_add_pkg::*;

    localparam int DW = DATA_PATH_BITWIDTH;

    logic [NUM_REQ-1:0]                  w_grant;
    logic [ID_W-1:0]                     w_winner;
    logic                                w_any;
    logic                                w_issue;
    logic                                w_cfg_hit;

    logic [ID_W-1:0]                     r_ptr;
    logic [NUM_REQ-1:0]                  r_mode;
    logic [ADD_LATENCY-1:0]              r_tag_vld;
    logic [ADD_LATENCY-1:0][ID_W-1:0]    r_tag_id;
    logic [NUM_REQ-1:0][CNT_W-1:0]       r_cnt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req    (req_valid),
        .ptr    (r_ptr),
        .grant  (w_grant),
        .winner (w_winner),
        .any    (w_any)
    );

    // Grants are suppressed while reset is held so nothing transfers during reset.
    assign w_issue   = rst & w_any;
    assign req_ready = w_issue ? w_grant : '0;

    // Out-of-range indices (only possible when NUM_REQ is not a power of two) are dropped.
    assign w_cfg_hit = cfg_we && ({1'b0, cfg_id} < (ID_W+1)'(NUM_REQ));

    always_comb begin
        add_a       = '0;
        add_b       = '0;
        add_apx_ctl = MODE_EXACT;
        if (w_issue) begin
            add_a       = req_a[int'(w_winner)*DW +: DW];
            add_b       = req_b[int'(w_winner)*DW +: DW];
            // Uses the registered mode, so a same-cycle cfg write only affects later issues.
            add_apx_ctl = r_mode[w_winner];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr     <= '0;
            r_mode    <= {NUM_REQ{MODE_EXACT}};
            r_tag_vld <= '0;
            r_tag_id  <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_issue) begin
                r_ptr <= (w_winner == ID_W'(NUM_REQ-1)) ? '0 : w_winner + 1'b1;
            end

            if (w_cfg_hit) begin
                r_mode[cfg_id] <= cfg_apx;
            end

            // Tag shift register mirrors the adder's register stages.
            r_tag_vld[0] <= w_issue;
            r_tag_id[0]  <= w_issue ? w_winner : '0;
            for (int i = 1; i < ADD_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_id[i]  <= r_tag_id[i-1];
            end

            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_issue && (w_winner == ID_W'(i)) && (r_mode[i] == MODE_APX)
                    && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign resp_valid = r_tag_vld[ADD_LATENCY-1];
    assign resp_id    = r_tag_id[ADD_LATENCY-1];
    assign resp_data  = add_c;
    assign apx_cnt    = r_cnt;

endmodule

// File: tb/tb_config_add_apx_arbiter.sv
// Directed bench for config_add_apx_arbiter with a two-stage truncation adder (4 low bits) alongside.
// Latency: expects responses two cycles after each grant.
// Backpressure: none exercised beyond round-robin grant selection.
module tb_config_add_apx_arbiter;

    logic          clk;
    logic          rst;
    logic [3:0]    req_valid;
    logic [127:0]  req_a;
    logic [127:0]  req_b;
    logic [3:0]    req_ready;
    logic          cfg_we;
    logic [1:0]    cfg_id;
    logic          cfg_apx;
    logic [31:0]   add_a;
    logic [31:0]   add_b;
    logic          add_apx_ctl;
    logic [31:0]   add_c;
    logic          resp_valid;
    logic [1:0]    resp_id;
    logic [31:0]   resp_data;
    logic [63:0]   apx_cnt;

    config_add_apx_arbiter #(
        .DATA_PATH_BITWIDTH (32),
        .NUM_REQ            (4),
        .ID_W               (2),
        .ADD_LATENCY        (2),
        .CNT_W              (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .cfg_we      (cfg_we),
        .cfg_id      (cfg_id),
        .cfg_apx     (cfg_apx),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_apx_ctl (add_apx_ctl),
        .add_c       (add_c),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_data   (resp_data),
        .apx_cnt     (apx_cnt)
    );

    // Shared truncation adder: input register then output register; approximate
    // mode zeroes the low 4 bits of both operands before adding.
    logic [31:0] m_a, m_b, m_c;
    logic        m_apx;
    always_ff @(posedge clk) begin
        m_a   <= add_a;
        m_b   <= add_b;
        m_apx <= add_apx_ctl;
        m_c   <= m_apx ? ((m_a & 32'hFFFF_FFF0) + (m_b & 32'hFFFF_FFF0)) : (m_a + m_b);
    end
    assign add_c = m_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Expected response pipeline: index 1 is what should be on resp_* this cycle.
    logic [1:0]  pv;
    logic [1:0]  pid [2];
    logic [31:0] pd  [2];

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  rdy;
        logic [31:0] sum;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive req_valid, check combinational grant/adder drive and
    // the registered response, then advance through the edge.
    task automatic apply(input string nm, input logic [3:0] vld, input logic [3:0] exp_rdy,
                         input logic exp_apx, input logic [31:0] exp_sum);
        int w;
        req_valid = vld;
        #2;
        chk({nm, " req_ready"}, 64'(req_ready), 64'(exp_rdy));
        w = 0;
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) w = i;
        end
        if (exp_rdy != 4'b0000) begin
            chk({nm, " add_a"}, 64'(add_a), 64'(req_a[w*32 +: 32]));
            chk({nm, " add_b"}, 64'(add_b), 64'(req_b[w*32 +: 32]));
            chk({nm, " add_apx_ctl"}, 64'(add_apx_ctl), 64'(exp_apx));
        end else begin
            chk({nm, " add_a idle"}, 64'(add_a), 64'd0);
            chk({nm, " add_apx_ctl idle"}, 64'(add_apx_ctl), 64'd0);
        end
        chk({nm, " resp_valid"}, 64'(resp_valid), 64'(pv[1]));
        if (pv[1]) begin
            chk({nm, " resp_id"}, 64'(resp_id), 64'(pid[1]));
            chk({nm, " resp_data"}, 64'(resp_data), 64'(pd[1]));
        end
        @(posedge clk);
        pv[1]  = pv[0];
        pid[1] = pid[0];
        pd[1]  = pd[0];
        pv[0]  = (exp_rdy != 4'b0000);
        pid[0] = 2'(w);
        pd[0]  = exp_sum;
        if (!rst) pv = '0;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        pv = '0;
        pid[0] = '0; pid[1] = '0;
        pd[0] = '0;  pd[1] = '0;

        // Operands per requester: 0x13+0x01, 0x100+0x23, 0xFFFFFFFF+0x2 (wraps), 0x7+0x9.
        req_a = {32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0100, 32'h0000_0013};
        req_b = {32'h0000_0009, 32'h0000_0002, 32'h0000_0023, 32'h0000_0001};

        tbl[0]  = '{4'b1111, 4'b0001, 32'h0000_0014};
        tbl[1]  = '{4'b1111, 4'b0010, 32'h0000_0123};
        tbl[2]  = '{4'b1111, 4'b0100, 32'h0000_0001};
        tbl[3]  = '{4'b1111, 4'b1000, 32'h0000_0010};
        tbl[4]  = '{4'b1111, 4'b0001, 32'h0000_0014};
        tbl[5]  = '{4'b1010, 4'b0010, 32'h0000_0123};
        tbl[6]  = '{4'b1010, 4'b1000, 32'h0000_0010};
        tbl[7]  = '{4'b0000, 4'b0000, 32'h0000_0000};
        tbl[8]  = '{4'b0100, 4'b0100, 32'h0000_0001};
        tbl[9]  = '{4'b0011, 4'b0001, 32'h0000_0014};
        tbl[10] = '{4'b0000, 4'b0000, 32'h0000_0000};
        tbl[11] = '{4'b0000, 4'b0000, 32'h0000_0000};

        // Reset held for three cycles with every requester asking.
        rst       = 1'b0;
        req_valid = 4'b1111;
        cfg_we    = 1'b0;
        cfg_id    = 2'd0;
        cfg_apx   = 1'b0;
        @(posedge clk);
        #1;
        apply("reset1", 4'b1111, 4'b0000, 1'b0, 32'h0);
        apply("reset2", 4'b1111, 4'b0000, 1'b0, 32'h0);
        chk("reset apx_cnt", apx_cnt, 64'h0);
        rst = 1'b1;

        // Round-robin table in exact mode.
        for (int i = 0; i < 12; i++) begin
            apply($sformatf("rr%0d", i), tbl[i].vld, tbl[i].rdy, 1'b0, tbl[i].sum);
        end

        // Approximate mode on requester 2 (pointer is at 1 here).
        cfg_we = 1'b1; cfg_id = 2'd2; cfg_apx = 1'b1;
        apply("cfg2", 4'b0000, 4'b0000, 1'b0, 32'h0);
        cfg_we = 1'b0;
        req_a[64 +: 32] = 32'h0000_001F;
        req_b[64 +: 32] = 32'h0000_0011;
        apply("apx2 issue", 4'b0100, 4'b0100, 1'b1, 32'h0000_0020);
        apply("apx2 drain1", 4'b0000, 4'b0000, 1'b0, 32'h0);
        apply("apx2 drain2", 4'b0000, 4'b0000, 1'b0, 32'h0);
        chk("apx_cnt[2] after one", 64'(apx_cnt[32 +: 16]), 64'd1);
        chk("apx_cnt[0] untouched", 64'(apx_cnt[0 +: 16]), 64'd0);

        // Same-cycle mode write and issue from requester 1 (pointer at 3).
        req_a[32 +: 32] = 32'h0000_0007;
        req_b[32 +: 32] = 32'h0000_0007;
        cfg_we = 1'b1; cfg_id = 2'd1; cfg_apx = 1'b1;
        apply("same-cycle old mode", 4'b0010, 4'b0010, 1'b0, 32'h0000_000E);
        cfg_we = 1'b0;
        apply("next issue apx", 4'b0010, 4'b0010, 1'b1, 32'h0000_0000);
        apply("same drain1", 4'b0000, 4'b0000, 1'b0, 32'h0);
        apply("same drain2", 4'b0000, 4'b0000, 1'b0, 32'h0);
        chk("apx_cnt[1] after one", 64'(apx_cnt[16 +: 16]), 64'd1);

        // Reset one cycle after an issue: that response must never appear.
        apply("pre-reset issue", 4'b0001, 4'b0001, 1'b0, 32'h0000_0014);
        rst = 1'b0;
        apply("mid reset", 4'b0000, 4'b0000, 1'b0, 32'h0);
        rst = 1'b1;
        apply("post reset1", 4'b0000, 4'b0000, 1'b0, 32'h0);
        apply("post reset2", 4'b0000, 4'b0000, 1'b0, 32'h0);
        chk("apx_cnt cleared", apx_cnt, 64'h0);
        apply("ptr reset grant0", 4'b1111, 4'b0001, 1'b0, 32'h0000_0014);

        // Saturation of requester 0's counter.
        cfg_we = 1'b1; cfg_id = 2'd0; cfg_apx = 1'b1;
        apply("cfg0", 4'b0000, 4'b0000, 1'b0, 32'h0);
        cfg_we = 1'b0;
        apply("cfg0 drain", 4'b0000, 4'b0000, 1'b0, 32'h0);
        req_valid = 4'b0001;
        repeat (65534) @(posedge clk);
        #1;
        req_valid = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        pv = '0;
        chk("apx_cnt[0] preload", 64'(apx_cnt[0 +: 16]), 64'h0000_FFFE);
        apply("sat issue1", 4'b0001, 4'b0001, 1'b1, 32'h0000_0010);
        apply("sat issue2", 4'b0001, 4'b0001, 1'b1, 32'h0000_0010);
        apply("sat issue3", 4'b0001, 4'b0001, 1'b1, 32'h0000_0010);
        apply("sat drain1", 4'b0000, 4'b0000, 1'b0, 32'h0);
        apply("sat drain2", 4'b0000, 4'b0000, 1'b0, 32'h0);
        chk("apx_cnt[0] saturated", 64'(apx_cnt[0 +: 16]), 64'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
